avr_decode_stage: RTL and testbench
===================================

# avr_decode_stage

Registered, parametrised instruction decode stage for the AVR core. It sits between program-memory fetch and execute. It buffers fetched program words in a small FIFO and assembles one- and two-word instructions (jmp, call, lds, sts). It presents each decoded opcode with its operand words over a valid/ready handshake, and drops an entire skipped instruction (1 or 2 words) on request from execute.

## Interface
Parameters:
- WORD_W, 16: program word width.
- PC_W, 16: program counter width tagged onto each instruction.
- OPCODE_W, 8: decoded opcode width.
- DEPTH, 4: word FIFO depth; power of two, minimum 2.

Ports:
- clk  in  1: single clock; all state changes on the rising edge.
- reset  in  1: synchronous, active-high reset.
- in_word  in  WORD_W: fetched program word.
- in_pc  in  PC_W: word address of in_word.
- in_valid  in  1: in_word/in_pc valid.
- in_ready  out  1: FIFO can accept a word.
- skip_req  in  1: one-cycle pulse; discard the next instruction.
- flush  in  1: one-cycle pulse; discard all buffered and presented state.
- out_valid  out  1: decoded instruction held on outputs.
- out_ready  in  1: execute accepts the instruction.
- out_opcode  out  OPCODE_W: decoded opcode code.
- out_word1  out  WORD_W: first instruction word.
- out_word2  out  WORD_W: second word; 0 for one-word instructions.
- out_pc  out  PC_W: pc of word1.
- out_len2  out  1: instruction is two words.
- illegal  out  1: one-cycle pulse when an error-coded instruction is loaded.

## Operation
- FIFO stores {in_pc, in_word}. Push when in_valid && in_ready. in_ready = !full; it stays deasserted while full, even if a pop happens in the same cycle.
- Classifier works on the head word. Two-word ops are jmp, call, lds and sts. An unmatched word decodes to error (0). Match priority and code numbering are fixed by the package table.
- Load condition: (!out_valid || out_ready) && (head is one-word && count≥1 || head is two-word && count≥2). On load, pop 1 or 2 words.
- States: RUN, SKIP.
  - RUN: load the output register normally.
  - SKIP: the next complete instruction is popped but not loaded. out_valid stays low for it; the state returns to RUN.
  - skip_req in RUN → SKIP. skip_req while already in SKIP is ignored (no stacking).
- A skip does not affect an instruction already held in the output register.
- flush has priority over everything. It empties the FIFO, clears out_valid, forces RUN, and drops any word presented on in_word that cycle.
- illegal pulses in the cycle after loading an error opcode. Skipped instructions never raise illegal.

## Timing
- Reset values: in_ready=1, out_valid=0, out_opcode=0, out_word1=0, out_word2=0, out_pc=0, out_len2=0, illegal=0; FIFO empty; state RUN.
- One-word latency: a word pushed in cycle T sets out_valid at T+2 when output is free.
- Two-word latency: out_valid two cycles after the second word is pushed.
- Throughput: one instruction per cycle under back-to-back one-word stream with out_ready held high.
- Outputs hold stable while out_valid && !out_ready.
- Reset or flush mid two-word assembly discards the partial word.
- skip_req in the same cycle as a load: that load completes normally, and the skip applies to the following instruction.

## Configuration
- AVR_DECODE_EXT_OPS_EN defined: the classifier also decodes mul, lpm Z+, brlt, brge, sbrc and sbrs. These use codes 46–51 in the package table.
- Without it: those encodings decode as error and raise illegal.
- All other behaviour is identical with or without the macro.

## Structure
- Package avr_decode_pkg holds:
  - All opcode localparams: error=0 through sub=45, plus extended codes 46–51.
  - Function is_two_word(word).
  - Function classify(word), with the extended cases guarded by the macro.
- Sub-module avr_word_fifo: synchronous FIFO parametrised by width and DEPTH. It outputs count, full and empty. Its head entry and head+1 entry are both readable.

## Test plan
- Reset, then push 16'hE0F5 (ldi) → out_opcode=1, out_len2=0, out_valid two cycles after push.
- Push 16'h940E, 16'h0123 (call) with a one-cycle gap between words → out_opcode=3, out_word2=16'h0123, out_len2=1, one load.
- Pulse skip_req, then push call (2 words) followed by 16'h0000 (nop) → call dropped, next output is nop (12), illegal stays 0.
- Hold out_ready=0 and push 5 words into a DEPTH=4 FIFO → in_ready falls after 4 buffered + 1 output; outputs stay stable; releasing out_ready drains all in order.
- Push 16'hFFFF → out_opcode=0 with a one-cycle illegal pulse. With AVR_DECODE_EXT_OPS_EN, 16'h9C12 (mul) → opcode 46.
- Assert flush while the first word of an lds is buffered and in_valid is high → FIFO empty, out_valid=0, in-flight word dropped, next push decodes cleanly.

Source files
------------

// File: rtl/avr_decode_pkg.sv
// avr_decode_pkg
// Shared opcode numbering and classification helpers for the AVR decode stage.
//   - OP_* localparams: decoded opcode codes (0 = error).
//   - is_two_word(word): high when the word starts a jmp/call/lds/sts.
//   - classify(word): maps a program word to its opcode code.
// Optional feature: AVR_DECODE_EXT_OPS_EN adds mul, lpm Z+, brlt, brge,
// sbrc and sbrs (codes 46-51); without it those encodings classify as error.
package avr_decode_pkg;

  localparam logic [7:0] OP_ERROR = 8'd0;
  localparam logic [7:0] OP_LDI   = 8'd1;
  localparam logic [7:0] OP_JMP   = 8'd2;
  localparam logic [7:0] OP_CALL  = 8'd3;
  localparam logic [7:0] OP_LDS   = 8'd4;
  localparam logic [7:0] OP_STS   = 8'd5;
  localparam logic [7:0] OP_RJMP  = 8'd6;
  localparam logic [7:0] OP_RCALL = 8'd7;
  localparam logic [7:0] OP_RET   = 8'd8;
  localparam logic [7:0] OP_RETI  = 8'd9;
  localparam logic [7:0] OP_IJMP  = 8'd10;
  localparam logic [7:0] OP_ICALL = 8'd11;
  localparam logic [7:0] OP_NOP   = 8'd12;
  localparam logic [7:0] OP_MOV   = 8'd13;
  localparam logic [7:0] OP_MOVW  = 8'd14;
  localparam logic [7:0] OP_ADD   = 8'd15;
  localparam logic [7:0] OP_ADC   = 8'd16;
  localparam logic [7:0] OP_ADIW  = 8'd17;
  localparam logic [7:0] OP_SBIW  = 8'd18;
  localparam logic [7:0] OP_SUBI  = 8'd19;
  localparam logic [7:0] OP_SBCI  = 8'd20;
  localparam logic [7:0] OP_SBC   = 8'd21;
  localparam logic [7:0] OP_CP    = 8'd22;
  localparam logic [7:0] OP_CPC   = 8'd23;
  localparam logic [7:0] OP_CPI   = 8'd24;
  localparam logic [7:0] OP_CPSE  = 8'd25;
  localparam logic [7:0] OP_AND   = 8'd26;
  localparam logic [7:0] OP_ANDI  = 8'd27;
  localparam logic [7:0] OP_OR    = 8'd28;
  localparam logic [7:0] OP_ORI   = 8'd29;
  localparam logic [7:0] OP_EOR   = 8'd30;
  localparam logic [7:0] OP_COM   = 8'd31;
  localparam logic [7:0] OP_NEG   = 8'd32;
  localparam logic [7:0] OP_SWAP  = 8'd33;
  localparam logic [7:0] OP_INC   = 8'd34;
  localparam logic [7:0] OP_ASR   = 8'd35;
  localparam logic [7:0] OP_LSR   = 8'd36;
  localparam logic [7:0] OP_ROR   = 8'd37;
  localparam logic [7:0] OP_DEC   = 8'd38;
  localparam logic [7:0] OP_PUSH  = 8'd39;
  localparam logic [7:0] OP_POP   = 8'd40;
  localparam logic [7:0] OP_IN    = 8'd41;
  localparam logic [7:0] OP_OUT   = 8'd42;
  localparam logic [7:0] OP_BREQ  = 8'd43;
  localparam logic [7:0] OP_BRNE  = 8'd44;
  localparam logic [7:0] OP_SUB   = 8'd45;
  // Extended set, only decoded when AVR_DECODE_EXT_OPS_EN is defined
  localparam logic [7:0] OP_MUL   = 8'd46;
  localparam logic [7:0] OP_LPMZP = 8'd47;
  localparam logic [7:0] OP_BRLT  = 8'd48;
  localparam logic [7:0] OP_BRGE  = 8'd49;
  localparam logic [7:0] OP_SBRC  = 8'd50;
  localparam logic [7:0] OP_SBRS  = 8'd51;

  function automatic logic hit(input logic [15:0] w, input logic [15:0] mask,
                               input logic [15:0] val);
    return (w & mask) == val;
  endfunction

  // jmp/call: 1001 010k kkkk 11xk ; lds/sts: 1001 00xd dddd 0000
  function automatic logic is_two_word(input logic [15:0] w);
    return hit(w, 16'hFE0C, 16'h940C) || hit(w, 16'hFC0F, 16'h9000);
  endfunction

  // Exact encodings are tested first so the wider masked families below
  // cannot shadow them.
  function automatic logic [7:0] classify(input logic [15:0] w);
    logic [7:0] code;
    code = OP_ERROR;
    if      (w == 16'h0000)                code = OP_NOP;
    else if (w == 16'h9508)                code = OP_RET;
    else if (w == 16'h9518)                code = OP_RETI;
    else if (w == 16'h9409)                code = OP_IJMP;
    else if (w == 16'h9509)                code = OP_ICALL;
    else if (hit(w, 16'hFE0E, 16'h940C))   code = OP_JMP;
    else if (hit(w, 16'hFE0E, 16'h940E))   code = OP_CALL;
    else if (hit(w, 16'hFE0F, 16'h9000))   code = OP_LDS;
    else if (hit(w, 16'hFE0F, 16'h9200))   code = OP_STS;
    else if (hit(w, 16'hF000, 16'hE000))   code = OP_LDI;
    else if (hit(w, 16'hF000, 16'hC000))   code = OP_RJMP;
    else if (hit(w, 16'hF000, 16'hD000))   code = OP_RCALL;
    else if (hit(w, 16'hFC00, 16'h2C00))   code = OP_MOV;
    else if (hit(w, 16'hFF00, 16'h0100))   code = OP_MOVW;
    else if (hit(w, 16'hFC00, 16'h0C00))   code = OP_ADD;
    else if (hit(w, 16'hFC00, 16'h1C00))   code = OP_ADC;
    else if (hit(w, 16'hFF00, 16'h9600))   code = OP_ADIW;
    else if (hit(w, 16'hFF00, 16'h9700))   code = OP_SBIW;
    else if (hit(w, 16'hF000, 16'h5000))   code = OP_SUBI;
    else if (hit(w, 16'hF000, 16'h4000))   code = OP_SBCI;
    else if (hit(w, 16'hFC00, 16'h0800))   code = OP_SBC;
    else if (hit(w, 16'hFC00, 16'h1400))   code = OP_CP;
    else if (hit(w, 16'hFC00, 16'h0400))   code = OP_CPC;
    else if (hit(w, 16'hF000, 16'h3000))   code = OP_CPI;
    else if (hit(w, 16'hFC00, 16'h1000))   code = OP_CPSE;
    else if (hit(w, 16'hFC00, 16'h2000))   code = OP_AND;
    else if (hit(w, 16'hF000, 16'h7000))   code = OP_ANDI;
    else if (hit(w, 16'hFC00, 16'h2800))   code = OP_OR;
    else if (hit(w, 16'hF000, 16'h6000))   code = OP_ORI;
    else if (hit(w, 16'hFC00, 16'h2400))   code = OP_EOR;
    else if (hit(w, 16'hFE0F, 16'h9400))   code = OP_COM;
    else if (hit(w, 16'hFE0F, 16'h9401))   code = OP_NEG;
    else if (hit(w, 16'hFE0F, 16'h9402))   code = OP_SWAP;
    else if (hit(w, 16'hFE0F, 16'h9403))   code = OP_INC;
    else if (hit(w, 16'hFE0F, 16'h9405))   code = OP_ASR;
    else if (hit(w, 16'hFE0F, 16'h9406))   code = OP_LSR;
    else if (hit(w, 16'hFE0F, 16'h9407))   code = OP_ROR;
    else if (hit(w, 16'hFE0F, 16'h940A))   code = OP_DEC;
    else if (hit(w, 16'hFE0F, 16'h920F))   code = OP_PUSH;
    else if (hit(w, 16'hFE0F, 16'h900F))   code = OP_POP;
    else if (hit(w, 16'hF800, 16'hB000))   code = OP_IN;
    else if (hit(w, 16'hF800, 16'hB800))   code = OP_OUT;
    else if (hit(w, 16'hFC07, 16'hF001))   code = OP_BREQ;
    else if (hit(w, 16'hFC07, 16'hF401))   code = OP_BRNE;
    else if (hit(w, 16'hFC00, 16'h1800))   code = OP_SUB;
`ifdef AVR_DECODE_EXT_OPS_EN
    else if (hit(w, 16'hFC00, 16'h9C00))   code = OP_MUL;
    else if (hit(w, 16'hFE0F, 16'h9005))   code = OP_LPMZP;
    else if (hit(w, 16'hFC07, 16'hF004))   code = OP_BRLT;
    else if (hit(w, 16'hFC07, 16'hF404))   code = OP_BRGE;
    else if (hit(w, 16'hFE08, 16'hFC00))   code = OP_SBRC;
    else if (hit(w, 16'hFE08, 16'hFE00))   code = OP_SBRS;
`endif
    return code;
  endfunction

endpackage

// File: rtl/avr_word_fifo.sv
// avr_word_fifo
// Synchronous FIFO holding fetched {pc, word} entries for the decode stage.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : synchronous empty (flush), overrides push
//   push, din    : write one entry (ignored while full)
//   pop_cnt      : entries to drop this cycle (0, 1 or 2; caller keeps <= count)
//   head         : entry at the read pointer
//   head_next    : low NEXT_W bits of the entry behind the head
//   count, full, empty : occupancy
module avr_word_fifo #(
  parameter int WIDTH  = 32,
  parameter int NEXT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic [1:0]               pop_cnt,
  output logic [WIDTH-1:0]         head,
  output logic [NEXT_W-1:0]        head_next,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [WIDTH-1:0] next_entry;
  logic             do_push;

  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign do_push     = push && !full;
  assign rd_ptr_next = rd_ptr + AW'(1);
  assign head        = mem[rd_ptr];
  assign next_entry  = mem[rd_ptr_next];
  assign head_next   = next_entry[NEXT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      // Pointer wraps naturally because DEPTH is a power of two
      rd_ptr <= rd_ptr + AW'(pop_cnt);
      count  <= count + CW'(do_push) - CW'(pop_cnt);
    end
  end

  // Storage carries data only, so it is left out of reset
  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/avr_decode_stage.sv
// avr_decode_stage
// Registered decode stage between program-memory fetch and execute. Fetched
// words are buffered in avr_word_fifo; one- and two-word instructions are
// assembled from the FIFO head and presented over a valid/ready handshake.
//   clk, reset            : clock, synchronous active-high reset
//   in_word/in_pc/in_valid/in_ready : fetch side (push on valid && ready)
//   skip_req              : drop the next complete instruction (no stacking)
//   flush                 : drop everything buffered and presented
//   out_valid/out_ready   : execute-side handshake
//   out_opcode, out_word1, out_word2, out_pc, out_len2 : decoded instruction
//   illegal               : one-cycle pulse alongside a loaded error opcode
// Optional feature: AVR_DECODE_EXT_OPS_EN (see avr_decode_pkg) widens the
// classifier; the stage itself is unchanged by it.
module avr_decode_stage #(
  parameter int WORD_W   = 16,
  parameter int PC_W     = 16,
  parameter int OPCODE_W = 8,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD_W-1:0]   in_word,
  input  logic [PC_W-1:0]     in_pc,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                skip_req,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [WORD_W-1:0]   out_word1,
  output logic [WORD_W-1:0]   out_word2,
  output logic [PC_W-1:0]     out_pc,
  output logic                out_len2,
  output logic                illegal
);
  import avr_decode_pkg::*;

  localparam int EW = PC_W + WORD_W;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {RUN, SKIP} state_t;
  state_t state;

  logic [EW-1:0]     head_p0;
  logic [WORD_W-1:0] next_word_p0;
  logic [WORD_W-1:0] head_word_p0;
  logic [PC_W-1:0]   head_pc_p0;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              two_p0;
  logic              avail_p0;
  logic              out_free;
  logic              take_p0;
  logic              load_p0;
  logic [1:0]        pop_cnt;
  logic [7:0]        code_p0;
  logic              push;

  avr_word_fifo #(
    .WIDTH  (EW),
    .NEXT_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .din       ({in_pc, in_word}),
    .pop_cnt   (pop_cnt),
    .head      (head_p0),
    .head_next (next_word_p0),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // in_ready depends only on the registered occupancy, so a same-cycle pop
  // never reopens the input.
  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;

  // ---- stage p0: classify FIFO head, decide pop/load ----
  assign head_word_p0 = head_p0[WORD_W-1:0];
  assign head_pc_p0   = head_p0[EW-1:WORD_W];
  assign two_p0       = is_two_word(16'(head_word_p0));
  assign code_p0      = classify(16'(head_word_p0));
  assign avail_p0     = !empty && (!two_p0 || (count >= CW'(2)));
  assign out_free     = !out_valid || out_ready;

  // In SKIP the instruction is consumed without touching the output register,
  // so it does not wait for the output to drain.
  assign take_p0 = !flush && avail_p0 && ((state == SKIP) || out_free);
  assign load_p0 = take_p0 && (state == RUN);
  assign pop_cnt = !take_p0 ? 2'd0 : (two_p0 ? 2'd2 : 2'd1);

  // ---- stage p1: output register and skip FSM ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_word1  <= '0;
      out_word2  <= '0;
      out_pc     <= '0;
      out_len2   <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      state     <= RUN;
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (load_p0) begin
        out_valid  <= 1'b1;
        out_opcode <= OPCODE_W'(code_p0);
        out_word1  <= head_word_p0;
        out_word2  <= two_p0 ? next_word_p0 : '0;
        out_pc     <= head_pc_p0;
        out_len2   <= two_p0;
        illegal    <= (code_p0 == OP_ERROR);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        // A skip raised alongside a load targets the instruction after it
        RUN:     if (skip_req) state <= SKIP;
        SKIP:    if (take_p0)  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_avr_decode_stage.sv
module tb_avr_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_word;
  logic [15:0] in_pc;
  logic        in_valid;
  logic        in_ready;
  logic        skip_req;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_opcode;
  logic [15:0] out_word1;
  logic [15:0] out_word2;
  logic [15:0] out_pc;
  logic        out_len2;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  avr_decode_stage #(
    .WORD_W(16), .PC_W(16), .OPCODE_W(8), .DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_word    (in_word),
    .in_pc      (in_pc),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .skip_req   (skip_req),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_word1  (out_word1),
    .out_word2  (out_word2),
    .out_pc     (out_pc),
    .out_len2   (out_len2),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] w1;
    logic [15:0] w2;
    logic        len2;
    logic [7:0]  op;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Waits at falling edges for out_valid; lat is the number of edges seen.
  task automatic wait_valid(input int max, output int lat);
    lat = 0;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic push_word(input logic [15:0] w, input logic [15:0] pc);
    in_valid = 1'b1;
    in_word  = w;
    in_pc    = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  int          lat;
  int          nvalid;
  logic [7:0]  first_op;
  logic [15:0] first_w1;
  logic [15:0] first_pc;
  logic        ill_seen;
  logic [15:0] pc;
  int          idx;

  initial begin
    vecs[0]  = '{16'hE0F5, 16'h0000, 1'b0, 8'd1};   // ldi
    vecs[1]  = '{16'h0000, 16'h0000, 1'b0, 8'd12};  // nop
    vecs[2]  = '{16'h2C01, 16'h0000, 1'b0, 8'd13};  // mov
    vecs[3]  = '{16'h0C12, 16'h0000, 1'b0, 8'd15};  // add
    vecs[4]  = '{16'hC123, 16'h0000, 1'b0, 8'd6};   // rjmp
    vecs[5]  = '{16'h9508, 16'h0000, 1'b0, 8'd8};   // ret
    vecs[6]  = '{16'hB80F, 16'h0000, 1'b0, 8'd42};  // out
    vecs[7]  = '{16'h1812, 16'h0000, 1'b0, 8'd45};  // sub
    vecs[8]  = '{16'hF011, 16'h0000, 1'b0, 8'd43};  // breq
    vecs[9]  = '{16'hFFFF, 16'h0000, 1'b0, 8'd0};   // error
    vecs[10] = '{16'h940C, 16'h1234, 1'b1, 8'd2};   // jmp
    vecs[11] = '{16'h9100, 16'h0060, 1'b1, 8'd4};   // lds
    vecs[12] = '{16'h9310, 16'h0061, 1'b1, 8'd5};   // sts
    vecs[13] = '{16'h940E, 16'h0123, 1'b1, 8'd3};   // call
`ifdef AVR_DECODE_EXT_OPS_EN
    vecs[14] = '{16'h9C12, 16'h0000, 1'b0, 8'd46};  // mul
    vecs[15] = '{16'hFE05, 16'h0000, 1'b0, 8'd51};  // sbrs
`else
    vecs[14] = '{16'h9C12, 16'h0000, 1'b0, 8'd0};
    vecs[15] = '{16'hFE05, 16'h0000, 1'b0, 8'd0};
`endif

    reset = 1'b1; in_word = '0; in_pc = '0; in_valid = 1'b0;
    skip_req = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready",  in_ready,   1);
    check("rst_out_valid", out_valid,  0);
    check("rst_opcode",    out_opcode, 0);
    check("rst_word1",     out_word1,  0);
    check("rst_word2",     out_word2,  0);
    check("rst_pc",        out_pc,     0);
    check("rst_len2",      out_len2,   0);
    check("rst_illegal",   illegal,    0);

    // Table: each instruction alone, two-word ones with a one-cycle gap
    for (int i = 0; i < NV; i++) begin
      pc = 16'h0100 + 16'(2 * i);
      @(posedge clk); #1;
      push_word(vecs[i].w1, pc);
      if (vecs[i].len2) begin
        @(negedge clk);
        check("gap_no_valid", out_valid, 0);
        @(posedge clk); #1;
        push_word(vecs[i].w2, pc + 16'd1);
      end
      wait_valid(10, lat);
      check("latency", lat,        2);
      check("opcode",  out_opcode, vecs[i].op);
      check("word1",   out_word1,  vecs[i].w1);
      check("word2",   out_word2,  vecs[i].len2 ? vecs[i].w2 : 16'h0000);
      check("pc",      out_pc,     pc);
      check("len2",    out_len2,   vecs[i].len2);
      check("illegal", illegal,    (vecs[i].op == 8'd0));
      @(negedge clk);
      check("one_shot_valid",   out_valid, 0);
      check("one_shot_illegal", illegal,   0);
    end

    // Skip: call is dropped whole, nop is the only output
    @(posedge clk); #1 skip_req = 1'b1;
    @(posedge clk); #1 skip_req = 1'b0;
    in_valid = 1'b1;
    in_word = 16'h940E; in_pc = 16'h0200; @(posedge clk); #1;
    in_word = 16'h0123; in_pc = 16'h0201; @(posedge clk); #1;
    in_word = 16'h0000; in_pc = 16'h0202; @(posedge clk); #1;
    in_valid = 1'b0;
    nvalid = 0; ill_seen = 1'b0; first_op = 8'hFF; first_w1 = 16'hFFFF; first_pc = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (illegal) ill_seen = 1'b1;
      if (out_valid) begin
        if (nvalid == 0) begin
          first_op = out_opcode; first_w1 = out_word1; first_pc = out_pc;
        end
        nvalid++;
      end
    end
    check("skip_n_out",   nvalid,   1);
    check("skip_opcode",  first_op, 8'd12);
    check("skip_word1",   first_w1, 16'h0000);
    check("skip_pc",      first_pc, 16'h0202);
    check("skip_illegal", ill_seen, 0);

    // Backpressure: 4 buffered + 1 held, then drain in order
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_word  = 16'hE001 + 16'(i);
      in_pc    = 16'h0300 + 16'(i);
      @(negedge clk);
      check("bp_in_ready_open", in_ready, 1);
      @(posedge clk); #1;
    end
    in_word = 16'hE0FF; in_pc = 16'h03FF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_full", in_ready,  0);
      check("bp_hold_valid",    out_valid, 1);
      check("bp_hold_word1",    out_word1, 16'hE001);
      check("bp_hold_pc",       out_pc,    16'h0300);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idx = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) begin
        if (idx < 5) begin
          check("drain_word1", out_word1, 16'hE001 + 16'(idx));
          check("drain_pc",    out_pc,    16'h0300 + 16'(idx));
        end
        idx++;
      end
    end
    check("drain_count", idx, 5);

    // Flush with a held output and a half-assembled lds, new word on input
    @(posedge clk); #1 out_ready = 1'b0;
    push_word(16'hE011, 16'h0400);
    push_word(16'h9100, 16'h0401);
    @(negedge clk);
    check("pre_flush_valid", out_valid, 1);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_word = 16'h0060; in_pc = 16'h0402;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready",  in_ready,  1);
    nvalid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid) nvalid++;
    end
    check("flush_quiet", nvalid, 0);
    @(posedge clk); #1;
    push_word(16'hE0AA, 16'h0410);
    wait_valid(10, lat);
    check("post_flush_latency", lat,        2);
    check("post_flush_opcode",  out_opcode, 8'd1);
    check("post_flush_word1",   out_word1,  16'hE0AA);
    check("post_flush_word2",   out_word2,  16'h0000);
    check("post_flush_pc",      out_pc,     16'h0410);
    check("post_flush_len2",    out_len2,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
